// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider (div_seq_ctrl).
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        REM  = 2'b01,
        DIVU = 2'b10,
        REMU = 2'b11
    } div_code_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } div_state_t;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = $clog2(DIV_DATA_W) + 1;

    // Signed codes have bit 1 clear, remainder codes have bit 0 set.
    function automatic logic div_is_signed(input div_code_t code);
        return !code[1];
    endfunction

    function automatic logic div_is_rem(input div_code_t code);
        return code[0];
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
    parameter int dataW = 32
) (
    input  logic [dataW-1:0] rem_i,
    input  logic             msb_i,
    input  logic [dataW-1:0] divisor_i,
    output logic [dataW-1:0] rem_o,
    output logic             q_bit_o
);

    logic [dataW:0] shifted;
    logic [dataW:0] diff;

    // The incoming partial remainder is always below the divisor, so the
    // shifted value is below twice the divisor and diff's top bit is a borrow.
    always_comb begin
        shifted = {rem_i, msb_i};
        diff    = shifted - {1'b0, divisor_i};
        q_bit_o = ~diff[dataW];
        rem_o   = q_bit_o ? diff[dataW-1:0] : shifted[dataW-1:0];
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential DIV/REM/DIVU/REMU unit: dataW restoring steps then a sign fix.
// Define DIV_EARLY_OUT_EN to bypass CALC for divide-by-zero and signed overflow.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int dataW = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       divCode,
    input  logic [dataW-1:0] dividend,
    input  logic [dataW-1:0] divisor,
    input  logic             kill,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [dataW-1:0] result
);

    localparam int CntW = $clog2(dataW) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(dataW - 1);

    div_state_t       state_q;
    div_code_t        code_q;
    logic [dataW-1:0] quot_q;
    logic [dataW-1:0] rem_q;
    logic [dataW-1:0] dsor_q;
    logic [dataW-1:0] result_q;
    logic [CntW-1:0]  cnt_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             dz_q;
    logic             ready_q;
    logic             busy_q;
    logic             valid_q;

    div_code_t        code_d;
    logic             sign_a_d;
    logic             sign_b_d;
    logic             dz_d;
    logic [dataW-1:0] a_mag_d;
    logic [dataW-1:0] b_mag_d;
    logic             accept_d;
    logic [dataW-1:0] rem_d;
    logic             q_bit_d;
    logic [dataW-1:0] quot_fix_d;
    logic [dataW-1:0] rem_fix_d;

    always_comb begin
        code_d     = div_code_t'(divCode);
        sign_a_d   = div_is_signed(code_d) & dividend[dataW-1];
        sign_b_d   = div_is_signed(code_d) & divisor[dataW-1];
        a_mag_d    = sign_a_d ? -dividend : dividend;
        b_mag_d    = sign_b_d ? -divisor : divisor;
        dz_d       = (divisor == '0);
        accept_d   = start && !kill && ((state_q == S_IDLE) || (state_q == S_DONE));
        // Sign flags are zero for unsigned codes, so no code check is needed here.
        quot_fix_d = dz_q ? '1 : ((sign_a_q ^ sign_b_q) ? -quot_q : quot_q);
        rem_fix_d  = sign_a_q ? -rem_q : rem_q;
    end

`ifdef DIV_EARLY_OUT_EN
    localparam logic [dataW-1:0] MinNeg = {1'b1, {(dataW-1){1'b0}}};
    logic ovf_d;
    assign ovf_d = div_is_signed(code_d) && (dividend == MinNeg) && (divisor == '1);
`endif

    div_step #(.dataW(dataW)) u_step (
        .rem_i     (rem_q),
        .msb_i     (quot_q[dataW-1]),
        .divisor_i (dsor_q),
        .rem_o     (rem_d),
        .q_bit_o   (q_bit_d)
    );

    // NOTE: every register, operands included, is cleared by reset so a
    // discarded operation leaves no residue visible after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            code_q   <= DIV;
            quot_q   <= '0;
            rem_q    <= '0;
            dsor_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept_d) begin
                        code_q   <= code_d;
                        quot_q   <= a_mag_d;
                        rem_q    <= '0;
                        dsor_q   <= b_mag_d;
                        sign_a_q <= sign_a_d;
                        sign_b_q <= sign_b_d;
                        dz_q     <= dz_d;
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CALC;
`ifdef DIV_EARLY_OUT_EN
                        // Preload the magnitudes the full iteration would produce.
                        if (dz_d || ovf_d) begin
                            quot_q  <= dz_d ? '1 : MinNeg;
                            rem_q   <= dz_d ? a_mag_d : '0;
                            state_q <= S_FIX;
                        end
`endif
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        rem_q  <= rem_d;
                        quot_q <= {quot_q[dataW-2:0], q_bit_d};
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == LastCnt) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    if (kill) begin
                        state_q <= S_IDLE;
                    end else begin
                        result_q <= div_is_rem(code_q) ? rem_fix_d : quot_fix_d;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign valid  = valid_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: vector table plus multi-cycle corner cases.
// Build with DIV_EARLY_OUT_EN defined to expect the short special-case latency.
module tb_div_seq_ctrl;
    import div_pkg::*;

    localparam int W       = 32;
    localparam int FullLat = W + 2;
`ifdef DIV_EARLY_OUT_EN
    localparam int EarlyLat = 2;
`else
    localparam int EarlyLat = W + 2;
`endif

    typedef struct {
        div_code_t    code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        logic         special;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         kill;
    logic [1:0]   divCode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         valid;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    div_seq_ctrl #(.dataW(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .divCode  (divCode),
        .dividend (dividend),
        .divisor  (divisor),
        .kill     (kill),
        .ready    (ready),
        .busy     (busy),
        .valid    (valid),
        .result   (result)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present a request in cycle 0; returns after the acceptance edge (cycle 1).
    task automatic launch(input div_code_t code, input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        divCode  = code;
        dividend = a;
        divisor  = b;
        cyc      = 0;
        tick();
        start    = 1'b0;
    endtask

    // Watch valid until cycle 'limit'; report first valid cycle (-1 if none) and pulse count.
    task automatic wait_valid(input int limit, output int seen_at, output int pulses);
        seen_at = -1;
        pulses  = 0;
        forever begin
            if (valid) begin
                pulses++;
                if (seen_at < 0) seen_at = cyc;
            end
            if (cyc >= limit) break;
            tick();
        end
    endtask

    vec_t vecs[15];

    initial begin
        int           at;
        int           n;
        logic [W-1:0] prev;

        vecs[0]  = '{DIV,  32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
        vecs[1]  = '{REM,  32'd100,        32'hFFFF_FFF9, 32'd2,         1'b0};
        vecs[2]  = '{DIVU, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 1'b0};
        vecs[3]  = '{REMU, 32'd7,          32'd0,         32'd7,         1'b1};
        vecs[4]  = '{DIV,  32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[6]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};
        vecs[7]  = '{REM,  32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 1'b0};
        vecs[8]  = '{DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        1'b0};
        vecs[9]  = '{REMU, 32'hFFFF_FFFF,  32'd10,        32'd5,         1'b0};
        vecs[10] = '{REM,  32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1'b1};
        vecs[11] = '{DIV,  32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[12] = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0};
        vecs[13] = '{REMU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
        vecs[14] = '{DIV,  32'd7,          32'd7,         32'd1,         1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        kill     = 1'b0;
        divCode  = 2'b00;
        dividend = '0;
        divisor  = '0;
        #2;
        check("reset ready",  32'(ready),  32'd1);
        check("reset busy",   32'(busy),   32'd0);
        check("reset valid",  32'(valid),  32'd0);
        check("reset result", result,      32'd0);
        #10;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            launch(vecs[i].code, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d busy", i), 32'(busy), 32'd1);
            wait_valid(FullLat + 2, at, n);
            check($sformatf("vec%0d latency", i), 32'(at), vecs[i].special ? 32'(EarlyLat) : 32'(FullLat));
            check($sformatf("vec%0d pulses", i), 32'(n), 32'd1);
            check($sformatf("vec%0d result", i), result, vecs[i].exp);
            check($sformatf("vec%0d ready", i), 32'(ready), 32'd1);
        end

        // Starts while busy must not disturb the running operation.
        launch(DIVU, 32'd1000, 32'd10);
        while (cyc < 5) tick();
        start = 1'b1; divCode = REMU; dividend = 32'd9; divisor = 32'd3;
        tick();
        start = 1'b0;
        while (cyc < 10) tick();
        start = 1'b1; divCode = DIV; dividend = 32'd77; divisor = 32'd4;
        tick();
        start = 1'b0;
        wait_valid(FullLat + 2, at, n);
        check("ignored-start latency", 32'(at), 32'(FullLat));
        check("ignored-start pulses",  32'(n),  32'd1);
        check("ignored-start result",  result,  32'd100);

        // Kill mid-CALC: back to IDLE next cycle, no valid, result kept.
        prev = result;
        launch(DIVU, 32'd50, 32'd5);
        while (cyc < 12) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill ready", 32'(ready), 32'd1);
        check("kill busy",  32'(busy),  32'd0);
        wait_valid(FullLat + 6, at, n);
        check("kill pulses", 32'(n), 32'd0);
        check("kill result", result, prev);

        // Kill beats start while idle.
        cyc = 0;
        start = 1'b1; kill = 1'b1; divCode = DIVU; dividend = 32'd6; divisor = 32'd3;
        tick();
        start = 1'b0; kill = 1'b0;
        check("kill+start busy",  32'(busy),  32'd0);
        check("kill+start ready", 32'(ready), 32'd1);
        wait_valid(FullLat + 4, at, n);
        check("kill+start pulses", 32'(n), 32'd0);

        // Back-to-back: new start accepted on the valid cycle.
        launch(DIVU, 32'd1000, 32'd10);
        while (!valid && cyc < FullLat + 4) tick();
        check("b2b first valid",   32'(valid), 32'd1);
        check("b2b first latency", 32'(cyc),   32'(FullLat));
        check("b2b first result",  result,     32'd100);
        launch(REM, 32'd100, 32'hFFFF_FFF9);
        check("b2b accepted busy", 32'(busy), 32'd1);
        check("b2b result held",   result,    32'd100);
        wait_valid(FullLat + 2, at, n);
        check("b2b second latency", 32'(at), 32'(FullLat));
        check("b2b second result",  result,  32'd2);

        // Asynchronous reset in the middle of CALC.
        launch(DIV, 32'd100, 32'hFFFF_FFF9);
        while (cyc < 20) tick();
        check("pre-reset busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset ready",  32'(ready), 32'd1);
        check("async reset busy",   32'(busy),  32'd0);
        check("async reset valid",  32'(valid), 32'd0);
        check("async reset result", result,     32'd0);
        #1;
        reset = 1'b0;
        cyc = 0;
        wait_valid(FullLat + 6, at, n);
        check("post-reset pulses", 32'(n),     32'd0);
        check("post-reset ready",  32'(ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
